// File: rtl/key_decoder_pkg.sv
// rtl/key_decoder_pkg.sv - shared types, constants and decode helpers for key_decoder
package key_decoder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE        = 2'd0,
        ST_PRESS_CHK   = 2'd1,
        ST_HELD        = 2'd2,
        ST_RELEASE_CHK = 2'd3
    } state_t;

    localparam int         NUM_KEYS  = 10;
    localparam logic [3:0] CODE_MAX  = 4'd9;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Active-low segments, bit order {g,f,e,d,c,b,a}
    function automatic logic [6:0] bcd_to_seg(input logic [3:0] code);
        case (code)
            4'd0:    return 7'b1000000;
            4'd1:    return 7'b1111001;
            4'd2:    return 7'b0100100;
            4'd3:    return 7'b0110000;
            4'd4:    return 7'b0011001;
            4'd5:    return 7'b0010010;
            4'd6:    return 7'b0000010;
            4'd7:    return 7'b1111000;
            4'd8:    return 7'b0000000;
            4'd9:    return 7'b0010000;
            default: return SEG_BLANK;
        endcase
    endfunction

    function automatic logic [NUM_KEYS-1:0] bcd_to_onehot(input logic [3:0] code);
        logic [NUM_KEYS-1:0] v;
        v = '0;
        if (code <= CODE_MAX) begin
            v[code] = 1'b1;
        end
        return v;
    endfunction

endpackage

// File: rtl/key_sync2.sv
// rtl/key_sync2.sv - parameterized-width two-flop synchronizer, async active-high reset
module key_sync2 #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/key_decoder.sv
// rtl/key_decoder.sv - debounced key decoder with one-deep event buffer; optional KEY_DECODER_SEG_EN display
module key_decoder
    import key_decoder_pkg::*;
#(
    parameter int STABLE_CYCLES = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [3:0]          L,
    input  logic                GS,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [3:0]          out_code,
    output logic [NUM_KEYS-1:0] out_onehot,
    output logic                key_held,
    output logic                overflow
`ifdef KEY_DECODER_SEG_EN
    ,
    output logic [6:0]          seg_n
`endif
);

    localparam int            CW      = $clog2(STABLE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES);

    localparam logic [1:0] IDLE        = ST_IDLE;
    localparam logic [1:0] PRESS_CHK   = ST_PRESS_CHK;
    localparam logic [1:0] HELD        = ST_HELD;
    localparam logic [1:0] RELEASE_CHK = ST_RELEASE_CHK;

    logic [4:0]    s;
    logic [1:0]    state;
    logic [3:0]    cap;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_inc;
    logic          s_valid;
    logic          s_match;
    logic          push;
    logic          pop;

    key_sync2 #(.WIDTH(5)) u_sync (
        .clk (clk),
        .rst (rst),
        .d   ({GS, L}),
        .q   (s)
    );

    assign s_valid  = s[4] && (s[3:0] <= CODE_MAX);
    assign s_match  = s_valid && (s[3:0] == cap);
    assign cnt_inc  = (cnt == CNT_MAX) ? cnt : cnt + 1'b1;
    assign push     = (state == PRESS_CHK) && s_match && (cnt_inc == CNT_MAX);
    assign pop      = out_valid && out_ready;
    assign key_held = (state == HELD) || (state == RELEASE_CHK);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cap   <= '0;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (s_valid) begin
                        cap   <= s[3:0];
                        cnt   <= '0;
                        state <= PRESS_CHK;
                    end
                end
                PRESS_CHK: begin
                    if (s_match) begin
                        cnt <= cnt_inc;
                        if (cnt_inc == CNT_MAX) begin
                            state <= HELD;
                        end
                    end else if (s_valid) begin
                        cap <= s[3:0];
                        cnt <= '0;
                    end else begin
                        state <= IDLE;
                    end
                end
                HELD: begin
                    if (!s_match) begin
                        cnt   <= '0;
                        state <= RELEASE_CHK;
                    end
                end
                default: begin
                    // A returning match is bounce: resume HELD without a new event
                    if (s_match) begin
                        state <= HELD;
                    end else begin
                        cnt <= cnt_inc;
                        if (cnt_inc == CNT_MAX) begin
                            state <= IDLE;
                        end
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid  <= 1'b0;
            out_code   <= '0;
            out_onehot <= '0;
            overflow   <= 1'b0;
        end else if (push) begin
            if (!out_valid || pop) begin
                out_valid  <= 1'b1;
                out_code   <= cap;
                out_onehot <= bcd_to_onehot(cap);
            end else begin
                overflow <= 1'b1;
            end
        end else if (pop) begin
            out_valid <= 1'b0;
        end
    end

`ifdef KEY_DECODER_SEG_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seg_n <= SEG_BLANK;
        end else if (push && (!out_valid || pop)) begin
            seg_n <= bcd_to_seg(cap);
        end
    end
`endif

endmodule

// File: tb/tb_key_decoder.sv
// tb/tb_key_decoder.sv - self-checking bench for key_decoder with STABLE_CYCLES=4
module tb_key_decoder;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] L;
    logic       GS;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] out_code;
    logic [9:0] out_onehot;
    logic       key_held;
    logic       overflow;
`ifdef KEY_DECODER_SEG_EN
    logic [6:0] seg_n;
`endif

    key_decoder #(.STABLE_CYCLES(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .L          (L),
        .GS         (GS),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_code   (out_code),
        .out_onehot (out_onehot),
        .key_held   (key_held),
        .overflow   (overflow)
`ifdef KEY_DECODER_SEG_EN
        ,
        .seg_n      (seg_n)
`endif
    );

    always #5 clk = ~clk;

    int         errors = 0;
    int         checks = 0;
    int         tcount;
    int         pulses;
    int         first_pulse;
    logic [3:0] pcode;
    logic [9:0] ponehot;
    logic       held_seen;
    logic       low_seen;

    typedef struct {
        logic [3:0] code;
        logic       gs;
        int         hold;
        int         exp_events;
        logic [3:0] exp_code;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic mark();
        tcount      = 0;
        pulses      = 0;
        first_pulse = -1;
        pcode       = '0;
        ponehot     = '0;
        held_seen   = 1'b0;
        low_seen    = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        tcount++;
        if (out_valid && out_ready) begin
            pulses++;
            if (first_pulse < 0) first_pulse = tcount;
            pcode   = out_code;
            ponehot = out_onehot;
        end
        if (key_held) held_seen = 1'b1;
        else          low_seen  = 1'b1;
    endtask

    task automatic drive(input logic [3:0] l, input logic g);
        L  = l;
        GS = g;
    endtask

    initial begin
        vecs[0] = '{code: 4'd9,  gs: 1'b1, hold: 10, exp_events: 1, exp_code: 4'd9};
        vecs[1] = '{code: 4'd10, gs: 1'b1, hold: 10, exp_events: 0, exp_code: 4'd0};
        vecs[2] = '{code: 4'd12, gs: 1'b1, hold: 30, exp_events: 0, exp_code: 4'd0};
        vecs[3] = '{code: 4'd15, gs: 1'b1, hold: 10, exp_events: 0, exp_code: 4'd0};
        vecs[4] = '{code: 4'd7,  gs: 1'b0, hold: 10, exp_events: 0, exp_code: 4'd0};
        vecs[5] = '{code: 4'd6,  gs: 1'b1, hold: 4,  exp_events: 0, exp_code: 4'd0};
        vecs[6] = '{code: 4'd6,  gs: 1'b1, hold: 5,  exp_events: 1, exp_code: 4'd6};
        vecs[7] = '{code: 4'd0,  gs: 1'b1, hold: 8,  exp_events: 1, exp_code: 4'd0};

        rst = 1'b1;
        out_ready = 1'b1;
        drive(4'd0, 1'b0);
        mark();
        repeat (3) tick();
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_code", out_code, 0);
        chk("rst_out_onehot", out_onehot, 0);
        chk("rst_key_held", key_held, 0);
        chk("rst_overflow", overflow, 0);
`ifdef KEY_DECODER_SEG_EN
        chk("rst_seg_n", seg_n, 7'h7F);
`endif
        rst = 1'b0;

        // Clean press of 5: event lands after edge E0+6
        drive(4'd5, 1'b1);
        mark();
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (i == 6) chk("press_held_before", key_held, 0);
            if (i == 7) chk("press_held_after", key_held, 1);
        end
        chk("press_latency", first_pulse, 7);
        chk("press_count", pulses, 1);
        chk("press_code", pcode, 5);
        chk("press_onehot", ponehot, 10'b0000100000);
`ifdef KEY_DECODER_SEG_EN
        chk("press_seg_n", seg_n, 7'b0010010);
`endif
        drive(4'd0, 1'b0);
        mark();
        for (int i = 1; i <= 10; i++) begin
            tick();
            if (i == 6) chk("release_held_before", key_held, 1);
            if (i == 7) chk("release_held_after", key_held, 0);
        end
        chk("release_no_event", pulses, 0);

        for (int v = 0; v < 8; v++) begin
            drive(vecs[v].code, vecs[v].gs);
            mark();
            repeat (vecs[v].hold) tick();
            drive(4'd0, 1'b0);
            repeat (12) tick();
            chk($sformatf("vec%0d_events", v), pulses, vecs[v].exp_events);
            chk($sformatf("vec%0d_code", v), pcode, vecs[v].exp_code);
            chk($sformatf("vec%0d_held_seen", v), held_seen, (vecs[v].exp_events != 0));
            chk($sformatf("vec%0d_held_end", v), key_held, 0);
        end

        // Press bounce: GS 1,0,1 then stable on code 3
        mark();
        drive(4'd3, 1'b1);
        tick();
        drive(4'd3, 1'b0);
        tick();
        drive(4'd3, 1'b1);
        mark();
        repeat (20) tick();
        chk("bounce_count", pulses, 1);
        chk("bounce_latency", first_pulse, 7);
        chk("bounce_code", pcode, 3);

        // Release bounce of 3 cycles in HELD: no second event, key stays held
        drive(4'd3, 1'b0);
        mark();
        repeat (3) tick();
        drive(4'd3, 1'b1);
        repeat (12) tick();
        chk("rbounce_events", pulses, 0);
        chk("rbounce_held_stable", low_seen, 0);
        drive(4'd0, 1'b0);
        repeat (12) tick();
        chk("rbounce_release", key_held, 0);

        // Backpressure: 2 buffered, 7 dropped
        out_ready = 1'b0;
        drive(4'd2, 1'b1); repeat (10) tick();
        drive(4'd0, 1'b0); repeat (12) tick();
        chk("bp_overflow_pre", overflow, 0);
        drive(4'd7, 1'b1); repeat (10) tick();
        drive(4'd0, 1'b0); repeat (12) tick();
        chk("bp_valid", out_valid, 1);
        chk("bp_code", out_code, 2);
        chk("bp_onehot", out_onehot, 10'b0000000100);
        chk("bp_overflow", overflow, 1);
        out_ready = 1'b1;
        tick();
        chk("bp_pop_valid", out_valid, 0);
        chk("bp_overflow_sticky", overflow, 1);

        rst = 1'b1;
        tick();
        chk("rst2_overflow", overflow, 0);
        rst = 1'b0;

        // Push of 8 coincides with pop of buffered 4
        out_ready = 1'b0;
        drive(4'd4, 1'b1); repeat (10) tick();
        drive(4'd0, 1'b0); repeat (12) tick();
        chk("pp_full_code", out_code, 4);
        drive(4'd8, 1'b1);
        for (int i = 1; i <= 7; i++) begin
            tick();
            if (i == 6) begin
                chk("pp_before_code", out_code, 4);
                out_ready = 1'b1;
            end
        end
        chk("pp_valid", out_valid, 1);
        chk("pp_code", out_code, 8);
        chk("pp_onehot", out_onehot, 10'b0100000000);
        chk("pp_overflow", overflow, 0);
        drive(4'd0, 1'b0);
        repeat (12) tick();
        chk("pp_drained", out_valid, 0);

        // Reset mid-press aborts code 3; code 0 then runs full latency
        drive(4'd3, 1'b1);
        repeat (4) tick();
        chk("mid_no_event_yet", out_valid, 0);
        rst = 1'b1;
        #1;
        chk("mid_rst_code", out_code, 0);
        chk("mid_rst_onehot", out_onehot, 0);
        chk("mid_rst_held", key_held, 0);
`ifdef KEY_DECODER_SEG_EN
        chk("mid_rst_seg_n", seg_n, 7'h7F);
`endif
        drive(4'd0, 1'b1);
        tick();
        tick();
        rst = 1'b0;
        mark();
        repeat (10) tick();
        chk("mid_latency", first_pulse, 7);
        chk("mid_count", pulses, 1);
        chk("mid_code", pcode, 0);
        chk("mid_onehot", ponehot, 10'b0000000001);
        chk("mid_held", key_held, 1);
`ifdef KEY_DECODER_SEG_EN
        chk("mid_seg_n", seg_n, 7'b1000000);
`endif
        drive(4'd0, 1'b0);
        repeat (12) tick();
        chk("final_held", key_held, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/key_decoder.md
# key_decoder

Receive-side counterpart of the keyboard encoder. Samples the encoded key bus (`L[3:0]`, `GS`) as asynchronous inputs and debounces it with a press/release state machine. Emits exactly one decoded event per debounced key press: BCD code plus one-hot key vector. Events pass through a one-deep valid/ready output buffer to the consumer logic.

## Interface
- `STABLE_CYCLES`, default 4: consecutive synchronized samples required to confirm a press or a release. Legal range is 1 to 255.
- `clk`  input  1  sole clock, rising edge.
- `rst`  input  1  reset; asynchronous and active-high.
- `L`  input  4  encoded key code; valid codes are 0 to 9. Asynchronous to `clk`.
- `GS`  input  1  key-present flag, high means a key is pressed. Asynchronous to `clk`.
- `out_valid`  output  1  buffered event available.
- `out_ready`  input  1  consumer accepts the event.
- `out_code`  output  4  BCD code of the buffered event.
- `out_onehot`  output  10  bit `out_code` set, all other bits clear.
- `key_held`  output  1  debounced pressed level.
- `overflow`  output  1  sticky flag: an event was dropped because the buffer was full.
- `seg_n`  output  7  present only with `KEY_DECODER_SEG_EN`. Active-low segments, bit order {g,f,e,d,c,b,a}.

## Operation
- **Input synchronization.** `{GS,L}` passes through a 2-flop synchronizer. The FSM sees only the synchronized value `s`.
- **Valid sample.** A sample is valid when `GS=1` and `L<=9`. Codes 10 to 15 with `GS=1` are treated as no key.
- **FSM states:** IDLE, PRESS_CHK, HELD, RELEASE_CHK.
  - **IDLE:** on a valid `s`, capture `cap=L`, clear `cnt`, go to PRESS_CHK.
  - **PRESS_CHK:** each edge with `s` valid and equal to `cap` increments `cnt`.
    - When the increment makes `cnt==STABLE_CYCLES`, confirm the press: push `cap`, go to HELD.
    - Valid `s` with a different code: recapture `cap`, clear `cnt`, stay in PRESS_CHK.
    - Non-valid `s`: go to IDLE.
  - **HELD:** any `s` that is not valid-and-equal-to-`cap` clears `cnt` and goes to RELEASE_CHK.
  - **RELEASE_CHK:** each edge with a non-matching `s` increments `cnt`.
    - `cnt==STABLE_CYCLES` goes to IDLE.
    - A matching `s` goes back to HELD; this is bounce, and no event is emitted.
- **Key roll-over.** A different key pressed while one is held counts as release. The new key requires a full pass IDLE → PRESS_CHK → HELD.
- **`key_held`** is 1 in HELD and RELEASE_CHK, and 0 otherwise.
- **Output buffer** is one entry.
  - Pop occurs on an edge with `out_valid & out_ready`.
  - Push to an empty buffer: load, set `out_valid`.
  - Push and pop on the same edge: load the new event, `out_valid` stays 1, no overflow.
  - Push to a full buffer without a pop: drop the event, keep the old entry, set `overflow`. `overflow` clears only on `rst`.
- **Counter width.** `cnt` is `$clog2(STABLE_CYCLES+1)` bits and saturates; it never wraps.

## Timing
- **Reset values:**
  - `out_valid=0`, `out_code=0`, `out_onehot=0`
  - `key_held=0`, `overflow=0`
  - `seg_n=7'h7F` (blank)
  - FSM in IDLE, `cnt=0`
  - synchronizer flops 0, which reads as no key
- **Reset mid-operation.** `rst` asserted during any state aborts the press/release in progress with no event. After deassertion the full latency applies again.
- **Press latency.** Let raw inputs be stable and valid from before edge E0.
  - E1: synchronized value visible.
  - E2: IDLE → PRESS_CHK.
  - E2+STABLE_CYCLES: confirm.
  - `out_valid=1` and `key_held=1` from edge E0+STABLE_CYCLES+2 onward.
- **Release latency.** With raw inputs going to no key before edge R0, `key_held` falls after edge R0+STABLE_CYCLES+2.
- **Throughput.** With `out_ready` held at 1, `out_valid` is high for exactly one cycle per event.
- **Output stability.** `out_code` and `out_onehot` are registered and stable while `out_valid=1`.

## Configuration
- `KEY_DECODER_SEG_EN` defined:
  - `seg_n` port exists.
  - A register loads the 7-segment pattern of each pushed code; dropped events do not load it.
  - The display holds the last displayed code until the next push.
  - Reset value is blank (`7'h7F`).
- `KEY_DECODER_SEG_EN` undefined: no `seg_n` port and no segment logic. All other behaviour is identical.

## Structure
- Package `key_decoder_pkg` holds:
  - the FSM state enum
  - `NUM_KEYS=10`
  - `CODE_MAX=4'd9`
  - `SEG_BLANK=7'h7F`
  - function `bcd_to_seg` (digits 0 to 9)
  - function `bcd_to_onehot`
- Sub-module `key_sync2`: parameterized-width 2-flop synchronizer with the same asynchronous active-high reset, instantiated at width 5.

## Test plan
All scenarios use `STABLE_CYCLES=4`.
1. **Clean press.** Raw `L=5`, `GS=1` for 20 cycles, `out_ready=1` → single `out_valid` pulse after edge E0+6 with `out_code=5` and `out_onehot=10'b0000100000`. `key_held` stays 1 until the release completes.
2. **Press bounce.** `GS` 1,0,1 on alternate cycles, then `L=3` stable → exactly one event, code 3, timed from the last input change. No event for the bounce.
3. **Invalid code.** `L=12`, `GS=1` for 30 cycles → no event, `key_held=0`. A release bounce in HELD shorter than 4 cycles → no second event.
4. **Backpressure.** `out_ready=0`; press/release 2, then press/release 7 → buffer holds code 2 and `overflow=1` after 7 confirms. Raising `out_ready` pops code 2, then `out_valid=0`.
5. **Simultaneous push/pop.** Full buffer (code 4) and `out_ready=1` on the same edge as the confirm of 8 → `out_code=8`, `out_valid=1`, `overflow=0`.
6. **Reset mid-press.** `rst` pulse in PRESS_CHK, then with `KEY_DECODER_SEG_EN` defined, press 0 → reset values restored, no stale event. After the event, `seg_n=7'b1000000`.
